// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array tile sequencer.
package sa_pkg;

    localparam int PE_SIZE_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int PSUM_WIDTH_DEF = 32;
    localparam int MAX_VEC_DEF    = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRELOAD,
        ST_LOAD,
        ST_STREAM,
        ST_WAIT,
        ST_DONE
    } state_e;

    function automatic int cnt_w(input int max_vec);
        return $clog2(max_vec + 1);
    endfunction

endpackage

// File: rtl/sa_tile_sequencer_if.sv
// Handshake, SA-side and result bundle of the tile sequencer; slave = sequencer, master = its environment.
interface sa_tile_sequencer_if #(
    parameter int PE_SIZE    = sa_pkg::PE_SIZE_DEF,
    parameter int DATA_WIDTH = sa_pkg::DATA_WIDTH_DEF,
    parameter int PSUM_WIDTH = sa_pkg::PSUM_WIDTH_DEF,
    parameter int MAX_VEC    = sa_pkg::MAX_VEC_DEF,
    parameter int CNT_W      = sa_pkg::cnt_w(MAX_VEC)
);
    logic                                  start_i;
    logic [CNT_W-1:0]                      num_vec_i;
    logic [PE_SIZE-1:0][DATA_WIDTH-1:0]    ifmap_i;
    logic                                  ifmap_valid_i;
    logic                                  ifmap_ready_o;
    logic [PE_SIZE-1:0][DATA_WIDTH-1:0]    w_vec_i;
    logic                                  w_valid_i;
    logic                                  w_ready_o;
    logic [PE_SIZE-1:0][DATA_WIDTH-1:0]    sa_ifmap_row_o;
    logic                                  sa_ifmap_preload_o;
    logic [PE_SIZE-1:0][DATA_WIDTH-1:0]    sa_weight_col_o;
    logic [PE_SIZE-1:0]                    sa_weight_en_col_o;
    logic [PE_SIZE-1:0][PSUM_WIDTH-1:0]    sa_psum_row_o;
    logic [PE_SIZE-1:0]                    sa_psum_en_row_o;
    logic [PE_SIZE-1:0][PSUM_WIDTH-1:0]    sa_psum_row_i;
    logic [PE_SIZE-1:0]                    sa_psum_en_row_i;
    logic [PE_SIZE-1:0][PSUM_WIDTH-1:0]    res_o;
    logic [PE_SIZE-1:0]                    res_en_o;
    logic                                  res_valid_o;
    logic                                  busy_o;
    logic                                  done_o;

    modport slave (
        input  start_i, num_vec_i, ifmap_i, ifmap_valid_i, w_vec_i, w_valid_i,
               sa_psum_row_i, sa_psum_en_row_i,
        output ifmap_ready_o, w_ready_o, sa_ifmap_row_o, sa_ifmap_preload_o,
               sa_weight_col_o, sa_weight_en_col_o, sa_psum_row_o, sa_psum_en_row_o,
               res_o, res_en_o, res_valid_o, busy_o, done_o
    );

    modport master (
        output start_i, num_vec_i, ifmap_i, ifmap_valid_i, w_vec_i, w_valid_i,
               sa_psum_row_i, sa_psum_en_row_i,
        input  ifmap_ready_o, w_ready_o, sa_ifmap_row_o, sa_ifmap_preload_o,
               sa_weight_col_o, sa_weight_en_col_o, sa_psum_row_o, sa_psum_en_row_o,
               res_o, res_en_o, res_valid_o, busy_o, done_o
    );

endinterface

// File: rtl/sa_lane_delay.sv
// Per-lane DEPTH-stage delay line carrying a data word and its enable bit.
module sa_lane_delay #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_data,
    input  logic         i_en,
    output logic [W-1:0] o_data,
    output logic         o_en
);
    logic [DEPTH-1:0][W-1:0] r_data;
    logic [DEPTH-1:0]        r_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
            r_en   <= '0;
        end else begin
            r_data[0] <= i_data;
            r_en[0]   <= i_en;
            for (int s = 1; s < DEPTH; s++) begin
                r_data[s] <= r_data[s-1];
                r_en[s]   <= r_en[s-1];
            end
        end
    end

    assign o_data = r_data[DEPTH-1];
    assign o_en   = r_en[DEPTH-1];

endmodule

// File: rtl/sa_tile_sequencer.sv
// Tile sequencer for one PE_SIZE x PE_SIZE systolic array: ifmap preload, skewed weight stream, result count.
// Optional SA_DESKEW_EN realigns SA psum lanes into whole result vectors.
module sa_tile_sequencer
    import sa_pkg::*;
#(
    parameter int PE_SIZE    = PE_SIZE_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int MAX_VEC    = MAX_VEC_DEF
) (
    input logic                clk,
    input logic                rst_n,
    sa_tile_sequencer_if.slave bus
);
    localparam int               CNT_W    = cnt_w(MAX_VEC);
    localparam int               ROW_W    = (PE_SIZE > 1) ? $clog2(PE_SIZE) : 1;
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_VEC);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PE_SIZE - 1);

    state_e                             r_state;
    state_e                             w_state_nxt;
    logic [PE_SIZE-1:0][DATA_WIDTH-1:0] r_ifbuf [PE_SIZE];
    logic [ROW_W-1:0]                   r_row;
    logic [CNT_W-1:0]                   r_num;
    logic [CNT_W-1:0]                   r_acc;
    logic [CNT_W-1:0]                   r_res;
    logic [CNT_W-1:0]                   w_res_nxt;
    logic                               w_start_ok;
    logic                               w_if_hs;
    logic                               w_w_hs;
    logic                               w_res_hit;
    logic                               w_row_last;

    assign w_start_ok = bus.start_i && (bus.num_vec_i != '0) && (bus.num_vec_i <= MAX_C);
    assign w_if_hs    = (r_state == ST_PRELOAD) && bus.ifmap_valid_i;
    assign w_w_hs     = (r_state == ST_STREAM) && bus.w_valid_i;
    assign w_row_last = (r_row == ROW_LAST);
    // Lane 0 is the last lane to finish, so its enable marks one completed vector.
    assign w_res_hit  = bus.sa_psum_en_row_i[0] && ((r_state == ST_STREAM) || (r_state == ST_WAIT));
    assign w_res_nxt  = r_res + CNT_W'(w_res_hit);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_start_ok) w_state_nxt = ST_PRELOAD;
            ST_PRELOAD: if (w_if_hs && w_row_last) w_state_nxt = ST_LOAD;
            ST_LOAD:    if (w_row_last) w_state_nxt = ST_STREAM;
            ST_STREAM:  if (w_w_hs && ((r_acc + CNT_W'(1)) == r_num)) w_state_nxt = ST_WAIT;
            ST_WAIT:    if (w_res_nxt == r_num) w_state_nxt = ST_DONE;
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
            r_num   <= '0;
            r_acc   <= '0;
            r_res   <= '0;
            for (int k = 0; k < PE_SIZE; k++) r_ifbuf[k] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_start_ok) begin
                r_num <= bus.num_vec_i;
                r_acc <= '0;
                r_res <= '0;
                r_row <= '0;
            end
            // r_row is the write pointer while preloading and the read pointer while loading.
            if (w_if_hs) begin
                r_ifbuf[r_row] <= bus.ifmap_i;
                r_row          <= w_row_last ? '0 : r_row + ROW_W'(1);
            end
            if (r_state == ST_LOAD) r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            if (w_w_hs) r_acc <= r_acc + CNT_W'(1);
            if (w_res_hit) r_res <= w_res_nxt;
        end
    end

    assign bus.ifmap_ready_o      = (r_state == ST_PRELOAD);
    assign bus.w_ready_o          = (r_state == ST_STREAM);
    assign bus.sa_ifmap_row_o     = (r_state == ST_LOAD) ? r_ifbuf[r_row] : '0;
    assign bus.sa_ifmap_preload_o = (r_state == ST_LOAD) && (r_row == '0);
    assign bus.busy_o             = (r_state != ST_IDLE);
    assign bus.done_o             = (r_state == ST_DONE);
    assign bus.sa_psum_row_o      = '0;

    logic [PE_SIZE-1:0][DATA_WIDTH-1:0] w_wcol;
    logic [PE_SIZE-1:0]                 w_wen;
    logic [PE_SIZE-1:0][PSUM_WIDTH-1:0] w_res;
    logic [PE_SIZE-1:0]                 w_res_en;

    // Lane PE_SIZE-1 leads with one stage; lane j trails with PE_SIZE-j stages.
    for (genvar j = 0; j < PE_SIZE; j++) begin : g_skew
        sa_lane_delay #(.W(DATA_WIDTH), .DEPTH(PE_SIZE - j)) u_skew (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_data (w_w_hs ? bus.w_vec_i[j] : '0),
            .i_en   (w_w_hs),
            .o_data (w_wcol[j]),
            .o_en   (w_wen[j])
        );
    end

    assign bus.sa_weight_col_o    = w_wcol;
    assign bus.sa_weight_en_col_o = w_wen;
    assign bus.sa_psum_en_row_o   = w_wen;

`ifdef SA_DESKEW_EN
    for (genvar j = 0; j < PE_SIZE; j++) begin : g_dsk
        sa_lane_delay #(.W(PSUM_WIDTH), .DEPTH(j + 1)) u_dsk (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_data (bus.sa_psum_row_i[j]),
            .i_en   (bus.sa_psum_en_row_i[j]),
            .o_data (w_res[j]),
            .o_en   (w_res_en[j])
        );
    end
    assign bus.res_valid_o = w_res_en[0];
`else
    for (genvar j = 0; j < PE_SIZE; j++) begin : g_dsk
        sa_lane_delay #(.W(PSUM_WIDTH), .DEPTH(1)) u_dsk (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_data (bus.sa_psum_row_i[j]),
            .i_en   (bus.sa_psum_en_row_i[j]),
            .o_data (w_res[j]),
            .o_en   (w_res_en[j])
        );
    end
    assign bus.res_valid_o = |w_res_en;
`endif

    assign bus.res_o    = w_res;
    assign bus.res_en_o = w_res_en;

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Scoreboard bench for sa_tile_sequencer with a behavioural SA stand-in.
module tb_sa_tile_sequencer;
    import sa_pkg::*;

    localparam int P  = 4;
    localparam int DW = 8;
    localparam int PW = 32;
    localparam int MV = 256;
    localparam int CW = cnt_w(MV);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   errs   = 0;
    int   checks = 0;
    bit   chk_en = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sa_tile_sequencer_if #(.PE_SIZE(P), .DATA_WIDTH(DW), .PSUM_WIDTH(PW), .MAX_VEC(MV)) bus ();

    sa_tile_sequencer #(.PE_SIZE(P), .DATA_WIDTH(DW), .PSUM_WIDTH(PW), .MAX_VEC(MV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [P*DW:0]     q_load [$];
    logic [P+P*DW-1:0] q_w [$];
    logic [P+P*PW-1:0] q_r [$];
    int                q_done [$];

    int             sl [4];
    int             ns;
    logic [P*DW-1:0] vv [4];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errs++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // SA stand-in: one cycle latency, lane j emits 100*(v+1)+j for its v-th enabled weight.
    int lane_cnt [P];
    always @(posedge clk) begin
        if (!rst_n || !bus.busy_o) begin
            bus.sa_psum_en_row_i <= '0;
            bus.sa_psum_row_i    <= '0;
            for (int j = 0; j < P; j++) lane_cnt[j] = 0;
        end else begin
            bus.sa_psum_en_row_i <= bus.sa_weight_en_col_o;
            for (int j = 0; j < P; j++) begin
                if (bus.sa_weight_en_col_o[j]) begin
                    bus.sa_psum_row_i[j] <= PW'(100 * (lane_cnt[j] + 1) + j);
                    lane_cnt[j] = lane_cnt[j] + 1;
                end else begin
                    bus.sa_psum_row_i[j] <= '0;
                end
            end
        end
    end

    // Expected skewed weights/results for accepts at offsets sl[0..ns-1] after the first accept.
    task automatic push_stream();
        int last;
        last = sl[ns-1];
        for (int t = 1; t <= last + P + 1; t++) begin
            logic [P-1:0]    en;
            logic [P*DW-1:0] col;
            logic [P*PW-1:0] rr;
            en = '0; col = '0; rr = '0;
            for (int j = 0; j < P; j++)
                for (int k = 0; k < ns; k++)
                    if (sl[k] + (P - j) == t) begin
                        en[j]            = 1'b1;
                        col[j*DW +: DW]  = vv[k][j*DW +: DW];
                        rr[j*PW +: PW]   = PW'(100 * (k + 1) + j);
                    end
            q_w.push_back({en, col});
`ifndef SA_DESKEW_EN
            if (en != '0) q_r.push_back({en, rr});
`endif
        end
`ifdef SA_DESKEW_EN
        for (int k = 0; k < ns; k++) begin
            logic [P*PW-1:0] rv;
            for (int j = 0; j < P; j++) rv[j*PW +: PW] = PW'(100 * (k + 1) + j);
            q_r.push_back({{P{1'b1}}, rv});
        end
`endif
        q_done.push_back(ns);
    endtask

    // Monitors
    logic [P*DW:0]     e_l;
    logic [P+P*DW-1:0] e_w;
    logic [P+P*PW-1:0] e_r;
    int                e_d;
    bit                w_act     = 1'b0;
    int                last_load = -10;
    int                cnt0      = 0;
    int                last0     = -10;

    always @(negedge clk) begin
        if (!rst_n) begin
            w_act = 1'b0;
            cnt0  = 0;
        end else begin
            if (bus.sa_ifmap_row_o != '0) begin
                if (q_load.size() == 0) fail_now("load_extra");
                else begin
                    e_l = q_load.pop_front();
                    chk("load_row", {bus.sa_ifmap_preload_o, bus.sa_ifmap_row_o}, e_l);
                    if (!e_l[P*DW]) chk("load_consec", cyc, last_load + 1);
                    last_load = cyc;
                end
            end
            if (chk_en && !w_act && bus.sa_weight_en_col_o != '0) begin
                if (q_w.size() == 0) fail_now("wen_extra");
                else w_act = 1'b1;
            end
            if (w_act) begin
                e_w = q_w.pop_front();
                chk("w_en", bus.sa_weight_en_col_o, e_w[P+P*DW-1 -: P]);
                chk("w_col", bus.sa_weight_col_o, e_w[P*DW-1:0]);
                chk("psum_en_o", bus.sa_psum_en_row_o, e_w[P+P*DW-1 -: P]);
                chk("psum_row_o", bus.sa_psum_row_o, '0);
                if (q_w.size() == 0) w_act = 1'b0;
            end
            if (chk_en && bus.res_valid_o) begin
                if (q_r.size() == 0) fail_now("res_extra");
                else begin
                    e_r = q_r.pop_front();
                    chk("res", {bus.res_en_o, bus.res_o}, e_r);
                end
            end
            if (bus.sa_psum_en_row_i[0]) begin
                cnt0++;
                last0 = cyc;
            end
            if (bus.done_o) begin
                if (q_done.size() == 0) fail_now("done_extra");
                else begin
                    e_d = q_done.pop_front();
                    chk("done_count", cnt0, e_d);
                    chk("done_latency", cyc, last0 + 1);
                end
                cnt0 = 0;
            end
        end
    end

    task automatic do_start(input int n);
        @(negedge clk);
        bus.start_i   = 1'b1;
        bus.num_vec_i = CW'(n);
        chk("ifrdy_before", bus.ifmap_ready_o, 1'b0);
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("ifrdy_rise", bus.ifmap_ready_o, 1'b1);
    endtask

    task automatic send_row(input logic [P*DW-1:0] row);
        bus.ifmap_valid_i = 1'b1;
        bus.ifmap_i       = row;
        @(negedge clk);
        bus.ifmap_valid_i = 1'b0;
    endtask

    task automatic rows4(input logic [P*DW-1:0] r0, r1, r2, r3);
        q_load.push_back({1'b1, r0});
        q_load.push_back({1'b0, r1});
        q_load.push_back({1'b0, r2});
        q_load.push_back({1'b0, r3});
        send_row(r0);
        send_row(r1);
        send_row(r2);
        send_row(r3);
    endtask

    task automatic stream(input logic [7:0] pat, input int len);
        int n;
        int vi;
        n = 0; vi = 0;
        while (!bus.w_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.w_ready_o) begin
            fail_now("w_ready_timeout");
            return;
        end
        for (int i = 0; i < len; i++) begin
            bus.w_valid_i = pat[i];
            bus.w_vec_i   = pat[i] ? vv[vi] : '0;
            if (pat[i]) vi++;
            @(negedge clk);
        end
        bus.w_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.done_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done_o) fail_now("done_timeout");
    endtask

    initial begin
        bus.start_i       = 1'b0;
        bus.num_vec_i     = '0;
        bus.ifmap_i       = '0;
        bus.ifmap_valid_i = 1'b0;
        bus.w_vec_i       = '0;
        bus.w_valid_i     = 1'b0;
        rst_n             = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_done", bus.done_o, 1'b0);
        chk("rst_ifrdy", bus.ifmap_ready_o, 1'b0);
        chk("rst_wrdy", bus.w_ready_o, 1'b0);
        chk("rst_row", {bus.sa_ifmap_preload_o, bus.sa_ifmap_row_o}, '0);
        chk("rst_wcol", {bus.sa_weight_en_col_o, bus.sa_weight_col_o}, '0);
        chk("rst_psum_o", {bus.sa_psum_en_row_o, bus.sa_psum_row_o}, '0);
        chk("rst_res", {bus.res_valid_o, bus.res_en_o, bus.res_o}, '0);
        rst_n = 1'b1;

        // Illegal starts: zero count and count above MAX_VEC.
        @(negedge clk);
        bus.start_i = 1'b1; bus.num_vec_i = CW'(0);
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("ill_zero_busy", bus.busy_o, 1'b0);
        bus.start_i = 1'b1; bus.num_vec_i = CW'(300);
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("ill_big_busy", {bus.busy_o, bus.ifmap_ready_o}, 2'b00);

        // Pass 1: gapped preload, four back-to-back vectors, start while busy ignored.
        sl = '{0, 1, 2, 3}; ns = 4;
        vv = '{32'h01020304, 32'h11121314, 32'h21222324, 32'h31323334};
        push_stream();
        q_load.push_back({1'b1, 32'h04040404});
        q_load.push_back({1'b0, 32'h03030303});
        q_load.push_back({1'b0, 32'h02020202});
        q_load.push_back({1'b0, 32'h01010101});
        do_start(4);
        bus.start_i = 1'b1; bus.num_vec_i = CW'(2);
        send_row(32'h04040404);
        bus.start_i = 1'b0;
        chk("busy_start_ign", {bus.busy_o, bus.ifmap_ready_o}, 2'b11);
        send_row(32'h03030303);
        repeat (2) @(negedge clk);
        chk("gap_still_pre", bus.ifmap_ready_o, 1'b1);
        send_row(32'h02020202);
        send_row(32'h01010101);
        stream(8'b0000_1111, 4);
        wait_done();

        // Pass 2 back-to-back: one bubble between two vectors.
        sl = '{0, 2, 0, 0}; ns = 2;
        vv = '{32'h41424344, 32'h51525354, 32'h0, 32'h0};
        push_stream();
        do_start(2);
        rows4(32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11121314);
        stream(8'b0000_0101, 3);
        wait_done();
        @(negedge clk);
        chk("idle_after_done", {bus.busy_o, bus.done_o}, 2'b00);

        // Pass 3: reset in the middle of STREAM, no done expected.
        vv = '{32'h61626364, 32'h71727374, 32'h81828384, 32'h91929394};
        do_start(4);
        rows4(32'h21212121, 32'h22222222, 32'h23232323, 32'h24242424);
        chk_en = 1'b0;
        stream(8'b0000_0011, 2);
        bus.w_valid_i = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        bus.w_valid_i = 1'b0;
        chk("abort_busy", {bus.busy_o, bus.w_ready_o, bus.done_o}, 3'b000);
        chk("abort_wen", bus.sa_weight_en_col_o, '0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_done", bus.busy_o, 1'b0);
        chk_en = 1'b1;

        // Pass 4: single vector.
        sl = '{0, 0, 0, 0}; ns = 1;
        vv = '{32'hA1A2A3A4, 32'h0, 32'h0, 32'h0};
        push_stream();
        do_start(1);
        rows4(32'h31313131, 32'h32323232, 32'h33333333, 32'h34343434);
        stream(8'b0000_0001, 1);
        wait_done();

        repeat (6) @(negedge clk);
        chk("q_load_empty", q_load.size(), 0);
        chk("q_w_empty", q_w.size(), 0);
        chk("q_r_empty", q_r.size(), 0);
        chk("q_done_empty", q_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sa_tile_sequencer.md
# sa_tile_sequencer

Parametrised tile sequencer that drives one PE_SIZE x PE_SIZE systolic array (SA) through a full tile pass: ifmap preload, diagonally skewed weight streaming with per-lane enables, and result collection. It replaces hand-sequenced stimulus with handshaked upstream interfaces and a state machine. It sits between the tile buffers and the SA instance inside the MMU. It optionally realigns (deskews) SA partial-sum outputs into whole result vectors.

## Interface
- PE_SIZE, 4, array dimension (lanes per vector)
- DATA_WIDTH, 8, ifmap/weight element width
- PSUM_WIDTH, 32, partial-sum element width
- MAX_VEC, 256, maximum weight vectors per tile; CNT_W = $clog2(MAX_VEC+1)

Ports. Lane j is bits [j*W +: W] of each vector port.
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start_i  in  1  begin a tile pass; sampled only in IDLE
- num_vec_i  in  CNT_W  weight vectors in this pass; sampled with start_i
- ifmap_i / ifmap_valid_i / ifmap_ready_o  in/in/out  DATA_WIDTH*PE_SIZE/1/1  ifmap row stream
- w_vec_i / w_valid_i / w_ready_o  in/in/out  DATA_WIDTH*PE_SIZE/1/1  weight vector stream
- sa_ifmap_row_o  out  DATA_WIDTH*PE_SIZE  to SA ifmap_row_i
- sa_ifmap_preload_o  out  1  to SA ifmap_preload_i
- sa_weight_col_o  out  DATA_WIDTH*PE_SIZE  to SA weight_col_i, skewed
- sa_weight_en_col_o  out  PE_SIZE  to SA weight_en_col_i
- sa_psum_row_o  out  PSUM_WIDTH*PE_SIZE  to SA psum_row_i; constant zero
- sa_psum_en_row_o  out  PE_SIZE  to SA psum_en_row_i; equals sa_weight_en_col_o
- sa_psum_row_i / sa_psum_en_row_i  in  PSUM_WIDTH*PE_SIZE / PE_SIZE  from SA outputs
- res_o / res_en_o / res_valid_o  out  PSUM_WIDTH*PE_SIZE / PE_SIZE / 1  result vector
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse at the end of a pass

## Operation
- States: IDLE -> PRELOAD -> LOAD -> STREAM -> WAIT -> DONE -> IDLE.
- IDLE: start_i=1 with num_vec_i in 1..MAX_VEC latches the count and moves to PRELOAD. The sequencer ignores start_i when num_vec_i is 0 or exceeds MAX_VEC, and ignores it in every state other than IDLE.
- PRELOAD: ifmap_ready_o=1. Each handshake stores one row in an internal PE_SIZE-entry buffer. Gaps between rows are allowed. When the PE_SIZE-th row is accepted, the state moves to LOAD.
- LOAD: PE_SIZE consecutive cycles. Each cycle drives buffered row k (k = 0..PE_SIZE-1, in acceptance order) on sa_ifmap_row_o. sa_ifmap_preload_o=1 only on k=0. The state then moves to STREAM.
- STREAM: w_ready_o=1 while vectors remain. An accepted vector enters a triangular skew register. When w_valid_i=0, a bubble enters: data 0, enable 0. After the last accept, the state moves to WAIT.
- Skew: lane j is delayed PE_SIZE-1-j cycles relative to lane PE_SIZE-1, so lane PE_SIZE-1 leads. Example for PE_SIZE=4 and back-to-back vectors: enables run 1000, 1100, 1110, 1111, 0111, 0011, 0001.
- WAIT: a result counter increments on each cycle where sa_psum_en_row_i[0]=1 (lane 0 finishes last). When the count equals the latched count, the state moves to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Reset values: every output is 0, all buffers, skew registers and counters are 0, and the state is IDLE.
- rst_n=0 at any point aborts the pass at the next edge. No done_o is issued for an aborted pass.
- Result arrivals outside WAIT are still counted, provided they occur during STREAM.

## Timing
- IDLE->PRELOAD: edge after start_i. ifmap_ready_o rises one cycle after the start_i edge.
- Preload latency: LOAD begins on the edge after the last row handshake.
- Weight lane PE_SIZE-1 appears on sa_weight_col_o one cycle after its w_ handshake. Lane j appears PE_SIZE-j cycles after the handshake.
- STREAM->WAIT on the edge of the last accept. Skew registers keep shifting and flush in PE_SIZE-1 further cycles.
- done_o is asserted the cycle after the final counted sa_psum_en_row_i[0].
- Back-to-back passes: start_i is accepted in the cycle after done_o (state IDLE).

## Configuration
- SA_DESKEW_EN defined:
  - Lane j of sa_psum_row_i and sa_psum_en_row_i passes through j+1 register stages.
  - res_o therefore carries one aligned vector.
  - res_en_o has all bits equal.
  - res_valid_o is sa_psum_en_row_i[0] delayed 1 cycle.
- SA_DESKEW_EN undefined:
  - One register stage on all lanes.
  - res_o and res_en_o are raw skewed copies.
  - res_valid_o is the OR of res_en_o.
- Counting and done_o behave identically in both modes.

## Structure
- Shared package sa_pkg holds:
  - the state enum
  - PE_SIZE, DATA_WIDTH and PSUM_WIDTH defaults
  - the CNT_W function
- One sub-module, sa_lane_delay: parametrised per-lane N-stage delay line with enable bit. It is instantiated for both the input skew and the output deskew.

## Test plan
All scenarios use PE_SIZE=4.
- Reset: hold rst_n=0 for 2 cycles -> all outputs 0, busy_o=0. Assert rst_n=0 mid-STREAM -> next edge IDLE and no done_o.
- Preload: rows 04040404, 03030303, 02020202, 01010101, row 2 with a 2-cycle valid gap -> LOAD emits the rows in that order on 4 consecutive cycles. Preload pulse is high only with 04040404.
- Skew: num_vec=4, back-to-back vectors 01020304 (lane3=01)… -> sa_weight_en_col_o is 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000. sa_psum_en_row_o matches.
- Bubble: num_vec=2 with w_valid_i low 1 cycle between vectors -> enable patterns are separated by one zero diagonal. Exactly 2 result counts occur, then done_o.
- Deskew (SA_DESKEW_EN): model SA lane j output = 100*(v+1)+j with skewed enables -> res_o lanes align per vector v and res_valid_o pulses 4 times.
- Illegal start: start_i with num_vec=0, and start_i during busy -> ignored, state unchanged.
